md_scheduler: RTL and testbench

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_pkg.sv | 56 +++++
 rtl/md_scheduler_if.sv | 44 ++++
 rtl/md_latency_counter.sv | 42 ++++
 rtl/md_scheduler.sv | 129 ++++++++++++
 tb/tb_md_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the mult/div issue scheduler.
//
// Holds the MDSel operation encodings used between the E stage, the scheduler
// and the mult/div datapath, the scheduler state encoding, the default busy
// latencies, and small decode helpers so every file classifies ops the same
// way.
// -----------------------------------------------------------------------------
package md_pkg;

  // Width of the remaining-cycles counter; latencies must fit (1..15).
  localparam int CNT_W = 4;

  // Default busy latencies for the long operations.
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  // MDSel encodings. Codes 7..15 are reserved and decode as "no operation".
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  // Scheduler state: idle, or a multiply / divide in flight.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // mult / multu
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // div / divu
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // mthi / mtlo: single-cycle writes to HI/LO, never make the unit busy.
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  // Operations that occupy the datapath for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage : md_pkg

// File: rtl/md_scheduler_if.sv
// -----------------------------------------------------------------------------
// md_scheduler_if -- bundle between the pipeline control and md_scheduler.
//
// Signals
//   Valid_E    pipeline -> sched  E stage holds a real instruction
//   MDSel_E    pipeline -> sched  E-stage mult/div op (md_op_e encoding)
//   DivZero_E  pipeline -> sched  forwarded rt operand of E-stage op is zero
//   MDUse_D    pipeline -> sched  D-stage instruction touches HI/LO or the unit
//   Start      sched -> datapath  capture operands at this edge
//   MDSel      sched -> datapath  op accompanying Start, 0 otherwise
//   Busy       sched -> pipeline  long operation in flight
//   Done       sched -> pipeline  last Busy cycle
//   Stall_D    sched -> pipeline  freeze F/D, bubble into E
//   Count      sched -> pipeline  remaining Busy cycles, 0 when idle
//
// Modports
//   master  the pipeline / environment side
//   slave   the scheduler itself
// -----------------------------------------------------------------------------
interface md_scheduler_if;
  import md_pkg::*;

  logic             Valid_E;
  logic [3:0]       MDSel_E;
  logic             DivZero_E;
  logic             MDUse_D;
  logic             Start;
  logic [3:0]       MDSel;
  logic             Busy;
  logic             Done;
  logic             Stall_D;
  logic [CNT_W-1:0] Count;

  modport master (
    output Valid_E, MDSel_E, DivZero_E, MDUse_D,
    input  Start, MDSel, Busy, Done, Stall_D, Count
  );

  modport slave (
    input  Valid_E, MDSel_E, DivZero_E, MDUse_D,
    output Start, MDSel, Busy, Done, Stall_D, Count
  );

endinterface : md_scheduler_if

// File: rtl/md_latency_counter.sv
// -----------------------------------------------------------------------------
// md_latency_counter -- remaining-busy-cycles counter for md_scheduler.
//
// Ports
//   CLK       clock, all updates on the rising edge
//   Reset     synchronous active-low reset, clears the count
//   load      load load_val this edge (wins over dec)
//   load_val  latency to load
//   dec       decrement by one this edge; ignored at zero so it never wraps
//   count     current remaining cycles
//   is_zero   count == 0
//   is_one    count == 1 (final busy cycle)
// -----------------------------------------------------------------------------
module md_latency_counter
  import md_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_one
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples its inputs from before the clock edge.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == CNT_W'(1));

endmodule : md_latency_counter

// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler -- issue/occupancy sequencer for the multi-cycle mult/div unit.
//
// Decides when the E-stage instruction may launch an operation on the
// mult/div datapath, tracks how long a mult/div keeps the unit busy, and
// stalls the D stage when its instruction needs HI/LO (or the unit) while a
// result is still being produced. It performs no arithmetic on operands.
//
// Parameters
//   MULT_LAT  busy cycles for mult/multu (1..15)
//   DIV_LAT   busy cycles for div/divu   (1..15)
//
// Ports
//   CLK    clock, all state changes on the rising edge
//   Reset  synchronous active-low reset
//   md     md_scheduler_if.slave bundle (see md_scheduler_if.sv)
//
// Timing
//   Start, MDSel, Stall_D are combinational from state and inputs.
//   Busy, Done, Count depend only on registered state.
//   Start in cycle t makes Busy high for exactly MULT_LAT/DIV_LAT cycles from
//   t+1; Done marks the last of them and Count runs LAT..1, then back to 0.
// -----------------------------------------------------------------------------
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic         CLK,
  input  logic         Reset,
  md_scheduler_if.slave md
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  md_state_e        state;
  logic [3:0]       op;
  logic             busy;
  logic             start;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] count;
  logic             cnt_zero;
  logic             cnt_one;

  assign op   = md.MDSel_E;
  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Issue decision. Only an idle unit accepts work; an overlapping request while
  // busy is ignored (the pipeline keeps it stalled via Stall_D). A divide by a
  // zero divisor never launches, leaving HI/LO untouched. Start is also held
  // low during reset so the datapath never captures in a reset cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    start = 1'b0;
    if (Reset && !busy && md.Valid_E) begin
      if (is_mul_op(op) || is_move_op(op)) begin
        start = 1'b1;
      end else if (is_div_op(op) && !md.DivZero_E) begin
        start = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Latency counter: loaded on a long-op issue, counts down while busy.
  // ---------------------------------------------------------------------------
  assign cnt_load     = start && is_long_op(op);
  assign cnt_load_val = is_mul_op(op) ? MULT_CNT : DIV_CNT;
  assign cnt_dec      = busy && !cnt_zero;

  md_latency_counter u_counter (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (count),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  // ---------------------------------------------------------------------------
  // State machine. Moves are single-cycle and never change state; only mult/div
  // leave IDLE. The final busy cycle (Count == 1) returns to IDLE at the next
  // edge, which is the same edge the counter reaches zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && is_mul_op(op)) begin
            state <= ST_MUL;
          end else if (start && is_div_op(op)) begin
            state <= ST_DIV;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_one) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // Stall_D covers the issue cycle of a long op as well as every busy cycle, so
  // a dependent mfhi/mflo in D waits until the cycle after Done, when HI/LO
  // hold the final result.
  // ---------------------------------------------------------------------------
  assign md.Start   = start;
  assign md.MDSel   = start ? op : MD_NONE;
  assign md.Busy    = busy;
  assign md.Done    = busy && cnt_one;
  assign md.Count   = count;
  assign md.Stall_D = md.MDUse_D && (busy || (start && is_long_op(op)));

endmodule : md_scheduler

// File: tb/tb_md_scheduler.sv
// -----------------------------------------------------------------------------
// tb_md_scheduler -- directed self-checking bench for md_scheduler
// (MULT_LAT = 5, DIV_LAT = 10).
//
// Inputs change 1 time unit after a rising edge; outputs are sampled a further
// 1 time unit later, well away from the next edge. Each sample compares the
// packed vector {Start, MDSel, Busy, Done, Stall_D, Count} against a
// hand-computed value.
// -----------------------------------------------------------------------------
module tb_md_scheduler;

  logic clk;
  logic reset;

  int tests;
  int fails;

  md_scheduler_if bus ();

  md_scheduler #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .CLK   (clk),
    .Reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs: start, mdsel[3:0], busy, done, stall, count[3:0]
  logic [11:0] obs;
  assign obs = {bus.Start, bus.MDSel, bus.Busy, bus.Done, bus.Stall_D, bus.Count};

  function automatic logic [11:0] ev(input logic s, input logic [3:0] sel,
                                     input logic b, input logic d,
                                     input logic st, input logic [3:0] c);
    return {s, sel, b, d, st, c};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic dz, input logic use_d);
    bus.Valid_E   = v;
    bus.MDSel_E   = op;
    bus.DivZero_E = dz;
    bus.MDUse_D   = use_d;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [11:0] e;
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    // A mult request during reset must not start; Stall_D follows.
    drive(1'b1, 4'd1, 1'b0, 1'b1);
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_hold: got %b want %b", obs, e);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_release: got %b want %b", obs, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mult();
    logic [11:0] e;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    #1;
    e = ev(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL mult_issue: got %b want %b", obs, e);
    end
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      e = ev(1'b0, 4'd0, 1'b1, (i == 4), 1'b0, 4'(5 - i));
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL mult_busy_%0d: got %b want %b", i, obs, e);
      end
      cyc();
    end
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL mult_end: got %b want %b", obs, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_divu_stall();
    logic [11:0] e;
    int stall_cycles;
    stall_cycles = 0;
    drive(1'b1, 4'd4, 1'b0, 1'b1);
    #1;
    e = ev(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL divu_issue: got %b want %b", obs, e);
    end
    if (bus.Stall_D === 1'b1) stall_cycles++;
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      e = ev(1'b0, 4'd0, 1'b1, (i == 9), 1'b1, 4'(10 - i));
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL divu_busy_%0d: got %b want %b", i, obs, e);
      end
      if (bus.Stall_D === 1'b1) stall_cycles++;
      cyc();
    end
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL divu_release: got %b want %b", obs, e);
    end
    tests++;
    if (stall_cycles != 11) begin
      fails++;
      $display("FAIL divu_stall_total: got %0d want 11", stall_cycles);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div_zero();
    logic [11:0] e;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 1'b1, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL div_zero_issue: got %b want %b", obs, e);
    end
    drive(1'b1, 4'd4, 1'b1, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL divu_zero_issue: got %b want %b", obs, e);
    end
    cyc();
    // Following mfhi in D must not stall.
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL div_zero_mfhi: got %b want %b", obs, e);
    end
    cyc();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL div_zero_idle: got %b want %b", obs, e);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back_moves();
    logic [11:0] e;
    // mthi in E with mflo in D: single-cycle start, no stall.
    drive(1'b1, 4'd5, 1'b0, 1'b1);
    #1;
    e = ev(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL mthi_issue: got %b want %b", obs, e);
    end
    cyc();
    // mflo reaches E (MDSel_E = none).
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL mflo_after_mthi: got %b want %b", obs, e);
    end
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    #1;
    e = ev(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL mtlo_issue: got %b want %b", obs, e);
    end
    // Reserved code decodes as none.
    drive(1'b1, 4'd9, 1'b0, 1'b1);
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reserved_op: got %b want %b", obs, e);
    end
    // Bubble in E with a mult code must not start.
    drive(1'b0, 4'd1, 1'b0, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL bubble_mult: got %b want %b", obs, e);
    end
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL moves_never_busy: got %b want %b", obs, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_op();
    logic [11:0] e;
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    #1;
    e = ev(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_div_issue: got %b want %b", obs, e);
    end
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc();
    #1;
    e = ev(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_div_count3: got %b want %b", obs, e);
    end
    // Assert reset with a competing mult request: Start must stay low.
    reset = 1'b0;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_no_start: got %b want %b", obs, e);
    end
    cyc();
    reset = 1'b1;
    #1;
    // Aborted: idle, no Done, and the new mult is accepted at once.
    e = ev(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_abort_new_mult: got %b want %b", obs, e);
    end
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    e = ev(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_mult_running: got %b want %b", obs, e);
    end
    for (int i = 0; i < 5; i++) cyc();
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rst_mult_drain: got %b want %b", obs, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overlap();
    logic [11:0] e;
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    cyc();
    e = ev(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd4);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL overlap_count4: got %b want %b", obs, e);
    end
    // Force a div into E while busy; it must be ignored.
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    #1;
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL overlap_no_start: got %b want %b", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      e = ev(1'b0, 4'd0, 1'b1, (i == 2), 1'b0, 4'(3 - i));
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL overlap_busy_%0d: got %b want %b", i, obs, e);
      end
    end
    cyc();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    e = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL overlap_end: got %b want %b", obs, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_mult();
    test_divu_stall();
    test_div_zero();
    test_back_to_back_moves();
    test_reset_mid_op();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_md_scheduler
